// File: rtl/cache_mem_arbiter_pkg.sv
// Shared LC-3b type package.
//   lc3b_word   : 16-bit machine word, also used as the byte address type
//   lc3b_block  : one cache line
//   arb_state_t : states of the cache/memory arbiter
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter_grant_sel.sv
// arb_grant_sel: grant policy for the cache/memory arbiter.
// Purely combinational; chooses which cache to serve from IDLE.
//   i_req      in  icache requesting
//   d_req      in  dcache requesting (read or write)
//   last_grant in  cache granted last (0 = dcache, 1 = icache)
//   next_state out ARB_IDLE, ARB_SERVE_I or ARB_SERVE_D
// RR_EN = 0 : fixed priority, dcache over icache (last_grant ignored).
// RR_EN = 1 : on a tie the cache not granted last wins.
module arb_grant_sel
  import lc3b_types::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic       i_req,
  input  logic       d_req,
  input  logic       last_grant,
  output arb_state_t next_state
);

  always_comb begin
    next_state = ARB_IDLE;
    if (i_req && d_req) begin
      next_state = (RR_EN && (last_grant == 1'b0)) ? ARB_SERVE_I : ARB_SERVE_D;
    end else if (d_req) begin
      next_state = ARB_SERVE_D;
    end else if (i_req) begin
      next_state = ARB_SERVE_I;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the single physical-memory port between the
// icache and dcache miss controllers. One requester is granted at a time and
// the grant is held until pmem_resp; the arbiter then returns to IDLE.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_read, i_address               icache line-fill request
//   i_rdata, i_resp                 icache line data / completion pulse
//   d_read, d_write, d_address,
//   d_wdata                         dcache fill / writeback request
//   d_rdata, d_resp                 dcache line data / completion pulse
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata        physical memory request
//   pmem_rdata, pmem_resp           physical memory data / completion
// Build option: define ARB_RR_EN for round-robin arbitration on ties;
// default is fixed priority with the dcache winning.
module cache_mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state_q;
  arb_state_t state_n;
  arb_state_t grant;
  logic       last_grant;

`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b0;
    end else if ((state_q == ARB_IDLE) && (grant != ARB_IDLE)) begin
      last_grant <= (grant == ARB_SERVE_I);
    end
  end
`else
  localparam bit RR_EN = 1'b0;

  assign last_grant = 1'b0;
`endif

  arb_grant_sel #(
    .RR_EN (RR_EN)
  ) u_grant_sel (
    .i_req      (i_read),
    .d_req      (d_read | d_write),
    .last_grant (last_grant),
    .next_state (grant)
  );

  // Read data fans out to both caches; each qualifies it with its own resp.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // A response arriving here is stray and dropped.
        state_n = grant;
      end
      ARB_SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_address;
        i_resp       = pmem_resp;
        if (pmem_resp) state_n = ARB_IDLE;
      end
      ARB_SERVE_D: begin
        // Read+write together is illegal; the writeback takes precedence.
        pmem_read    = d_read & ~d_write;
        pmem_write   = d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
        if (pmem_resp) state_n = ARB_IDLE;
      end
      default: begin
        state_n = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned LW = 128;

`ifdef ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(
    .ADDR_W (AW),
    .LINE_W (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the memory port (0 none, 1 icache, 2 dcache)
  // and which cache received the most recent grant (0 dcache, 1 icache).
  int owner   = 0;
  bit last    = 1'b0;
  bit i_done  = 1'b0;
  bit d_done  = 1'b0;
  bit chk_en  = 1'b0;
  int mem_cnt = -1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner   = 0;
    last    = 1'b0;
    mem_cnt = -1;
  endtask

  // Applies the arbitration rules to the values sampled at a rising edge.
  task automatic model_edge();
    bit ir;
    bit dr;
    i_done = 1'b0;
    d_done = 1'b0;
    ir = i_read;
    dr = d_read | d_write;
    if (!rst_n) begin
      model_reset();
    end else if (owner == 0) begin
      if (ir && dr) owner = (RR_MODE && !last) ? 1 : 2;
      else if (dr) owner = 2;
      else if (ir) owner = 1;
      if (owner == 1) last = 1'b1;
      else if (owner == 2) last = 1'b0;
    end else if (pmem_resp) begin
      i_done = (owner == 1);
      d_done = (owner == 2);
      owner  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Expected outputs follow directly from the current owner and inputs.
  logic          e_read, e_write, e_iresp, e_dresp;
  logic [AW-1:0] e_addr;
  logic [LW-1:0] e_wdata;

  always @(negedge clk) begin
    if (chk_en) begin
      e_read  = 1'b0;
      e_write = 1'b0;
      e_iresp = 1'b0;
      e_dresp = 1'b0;
      e_addr  = '0;
      e_wdata = '0;
      if (owner == 1) begin
        e_read  = 1'b1;
        e_addr  = i_address;
        e_iresp = pmem_resp;
      end else if (owner == 2) begin
        e_read  = d_read && !d_write;
        e_write = d_write;
        e_addr  = d_address;
        e_wdata = d_wdata;
        e_dresp = pmem_resp;
      end
      check("pmem_read", 128'(pmem_read), 128'(e_read));
      check("pmem_write", 128'(pmem_write), 128'(e_write));
      check("pmem_address", 128'(pmem_address), 128'(e_addr));
      check("pmem_wdata", pmem_wdata, e_wdata);
      check("i_resp", 128'(i_resp), 128'(e_iresp));
      check("d_resp", 128'(d_resp), 128'(e_dresp));
      check("i_rdata", i_rdata, pmem_rdata);
      check("d_rdata", d_rdata, pmem_rdata);
    end
  end

  logic [LW-1:0] exp_line;
  logic [AW-1:0] exp_a;

  initial begin
    // Reset asserted mid-cycle with an icache request pending.
    i_read    = 1'b1;
    i_address = 16'h1230;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_pmem_read", 128'(pmem_read), 128'(1'b0));
    check("rst_pmem_write", 128'(pmem_write), 128'(1'b0));
    check("rst_pmem_address", 128'(pmem_address), 128'(16'h0000));
    check("rst_i_resp", 128'(i_resp), 128'(1'b0));
    check("rst_d_resp", 128'(d_resp), 128'(1'b0));
    chk_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("first_grant_read", 128'(pmem_read), 128'(1'b1));
    check("first_grant_addr", 128'(pmem_address), 128'(16'h1230));

    // Reset in the middle of a transaction drops the strobe at once.
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_pmem_read", 128'(pmem_read), 128'(1'b0));
    i_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Icache fill alone, five cycles of memory latency.
    exp_line   = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    pmem_rdata = exp_line;
    i_read     = 1'b1;
    i_address  = 16'h0040;
    tick();
    check("ifill_addr", 128'(pmem_address), 128'(16'h0040));
    for (int k = 0; k < 4; k++) tick();
    pmem_resp = 1'b1;
    #1;
    check("ifill_i_resp", 128'(i_resp), 128'(1'b1));
    check("ifill_i_rdata", i_rdata, exp_line);
    check("ifill_d_resp", 128'(d_resp), 128'(1'b0));
    tick();
    i_read    = 1'b0;
    pmem_resp = 1'b0;
    #1;
    check("ifill_done_resp", 128'(i_resp), 128'(1'b0));
    check("ifill_done_read", 128'(pmem_read), 128'(1'b0));

    // Simultaneous requests: dcache first, icache after an idle cycle.
    i_read    = 1'b1;
    d_read    = 1'b1;
    d_address = 16'h8000;
    tick();
    check("tie_first_addr", 128'(pmem_address), 128'(16'h8000));
    pmem_resp = 1'b1;
    #1;
    check("tie_d_resp", 128'(d_resp), 128'(1'b1));
    tick();
    d_read    = 1'b0;
    pmem_resp = 1'b0;
    #1;
    check("tie_idle_gap", 128'(pmem_read), 128'(1'b0));
    tick();
    check("tie_second_addr", 128'(pmem_address), 128'(16'h0040));
    pmem_resp = 1'b1;
    tick();
    i_read    = 1'b0;
    pmem_resp = 1'b0;

    // Writeback, with an icache request arriving mid-transaction.
    exp_line  = 128'h0123456789ABCDEF_0123456789ABCDEF;
    d_write   = 1'b1;
    d_address = 16'h2F00;
    d_wdata   = exp_line;
    tick();
    check("wb_write", 128'(pmem_write), 128'(1'b1));
    check("wb_read", 128'(pmem_read), 128'(1'b0));
    check("wb_wdata", pmem_wdata, exp_line);
    i_read = 1'b1;
    tick();
    tick();
    check("wb_icache_waits", 128'(pmem_address), 128'(16'h2F00));
    pmem_resp = 1'b1;
    #1;
    check("wb_d_resp", 128'(d_resp), 128'(1'b1));
    check("wb_i_resp", 128'(i_resp), 128'(1'b0));
    tick();
    d_write   = 1'b0;
    pmem_resp = 1'b0;
    tick();
    check("wb_then_icache", 128'(pmem_address), 128'(16'h0040));
    pmem_resp = 1'b1;
    tick();
    i_read    = 1'b0;
    pmem_resp = 1'b0;
    tick();

    // Stray response while idle.
    pmem_resp = 1'b1;
    #1;
    check("stray_i_resp", 128'(i_resp), 128'(1'b0));
    check("stray_d_resp", 128'(d_resp), 128'(1'b0));
    tick();
    pmem_resp = 1'b0;
    #1;
    check("stray_still_idle", 128'(pmem_read), 128'(1'b0));

    // Both requests held across four transactions.
    i_read    = 1'b1;
    d_read    = 1'b1;
    d_address = 16'h8000;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_a = (RR_MODE && (k % 2 == 1)) ? 16'h0040 : 16'h8000;
      check("hold_grant_order", 128'(pmem_address), 128'(exp_a));
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
    end
    i_read = 1'b0;
    d_read = 1'b0;
    tick();
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c == 1500) begin
        rst_n     = 1'b0;
        model_reset();
        i_read    = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        pmem_resp = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
      end else begin
        pmem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (i_done) begin
          i_read = 1'b0;
        end else if (!i_read && ($urandom_range(3, 0) == 0)) begin
          i_read    = 1'b1;
          i_address = 16'($urandom());
        end
        if (d_done) begin
          d_read  = 1'b0;
          d_write = 1'b0;
        end else if (!d_read && !d_write && ($urandom_range(3, 0) == 0)) begin
          if ($urandom_range(1, 0) == 0) d_read = 1'b1;
          else d_write = 1'b1;
          d_address = 16'($urandom());
          d_wdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        if (owner != 0) begin
          if (mem_cnt < 0) mem_cnt = int'($urandom_range(4, 0));
          if (mem_cnt == 0) begin
            pmem_resp = 1'b1;
            mem_cnt   = -1;
          end else begin
            pmem_resp = 1'b0;
            mem_cnt--;
          end
        end else begin
          mem_cnt   = -1;
          pmem_resp = ($urandom_range(9, 0) == 0);
        end
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
